instr_encoder_loader: RTL and testbench

// - Producer end of the control decoder: encodes op/field tuples into 32-bit LEGv8 words and writes them into instruction memory.
// - Used by the bench and boot path to load programs. It handles the in_valid/in_ready handshake, a DEPTH-entry word FIFO, the imem address counter and a load FSM.
// - Supported ops: ADDS, SUBS, ADDI, SUBI, LDUR, STUR, B, BL, CBZ, BR.

---
 rtl/instr_encoder_loader_if.sv | 29 ++
 rtl/instr_encoder_loader.sv | 205 ++++++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_loader_if.sv
// Tuple-input and instruction-memory write bundle for the program loader.
// The master drives field tuples and the memory ready line. The slave (the loader)
// answers with in_ready and drives the write bus.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rn;
    logic [4:0]        in_rm;
    logic [25:0]       in_imm;
    logic              in_last;
    logic              imem_wr_en;
    logic              imem_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_op, in_rd, in_rn, in_rm, in_imm, in_last, imem_ready,
        input  in_ready, imem_wr_en, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rn, in_rm, in_imm, in_last, imem_ready,
        output in_ready, imem_wr_en, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// LEGv8 program loader. It encodes op/field tuples into 32-bit instruction words,
// buffers them in a small FIFO, and writes them to consecutive instruction-memory
// addresses that start at base_addr. A load session runs IDLE -> LOAD -> DRAIN -> DONE.
module instr_encoder_loader #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    instr_encoder_loader_if.slave bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [7:0]            err_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [3:0] OP_ADDS = 4'd0;
    localparam logic [3:0] OP_SUBS = 4'd1;
    localparam logic [3:0] OP_ADDI = 4'd2;
    localparam logic [3:0] OP_SUBI = 4'd3;
    localparam logic [3:0] OP_LDUR = 4'd4;
    localparam logic [3:0] OP_STUR = 4'd5;
    localparam logic [3:0] OP_B    = 4'd6;
    localparam logic [3:0] OP_BL   = 4'd7;
    localparam logic [3:0] OP_CBZ  = 4'd8;
    localparam logic [3:0] OP_BR   = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic        legal;
        logic [31:0] word;
    } enc_t;

    // An immediate fits a signed N-bit field when every bit above the field
    // equals the sign bit, i.e. the upper slice is all ones or all zeros.
    function automatic enc_t encode(input logic [3:0]  op,
                                    input logic [4:0]  rd,
                                    input logic [4:0]  rn,
                                    input logic [4:0]  rm,
                                    input logic [25:0] imm);
        enc_t e;
        e.legal = 1'b1;
        e.word  = '0;
        case (op)
            OP_ADDS: e.word = {11'h558, rm, 6'b0, rn, rd};
            OP_SUBS: e.word = {11'h758, rm, 6'b0, rn, rd};
            OP_ADDI: begin
                e.word  = {10'h244, imm[11:0], rn, rd};
                e.legal = (imm[25:12] == '0);
            end
            OP_SUBI: begin
                e.word  = {10'h344, imm[11:0], rn, rd};
                e.legal = (imm[25:12] == '0);
            end
            OP_LDUR: begin
                e.word  = {11'h7C2, imm[8:0], 2'b00, rn, rd};
                e.legal = (&imm[25:8]) | ~(|imm[25:8]);
            end
            OP_STUR: begin
                e.word  = {11'h7C0, imm[8:0], 2'b00, rn, rd};
                e.legal = (&imm[25:8]) | ~(|imm[25:8]);
            end
            OP_B:    e.word = {6'b000101, imm};
            OP_BL:   e.word = {6'b100101, imm};
            OP_CBZ: begin
                e.word  = {8'hB4, imm[18:0], rd};
                e.legal = (&imm[25:18]) | ~(|imm[25:18]);
            end
            OP_BR:   e.word = {22'h3587C0, rn, 5'b0};
            default: e.legal = 1'b0;
        endcase
        return e;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_q, err_d;
    logic [7:0]         err_count_q, err_count_d;
    logic [31:0]        mem_q [DEPTH];
    logic [31:0]        mem_d [DEPTH];

    enc_t enc;
    logic fifo_full;
    logic fifo_empty;
    logic in_ready_w;
    logic accept;
    logic push;
    logic pop;

    assign enc        = encode(bus.in_op, bus.in_rd, bus.in_rn, bus.in_rm, bus.in_imm);
    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign in_ready_w = (state_q == S_LOAD) & ~fifo_full;
    assign accept     = bus.in_valid & in_ready_w;
    assign push       = accept & enc.legal;
    assign pop        = ~fifo_empty & bus.imem_ready;

    assign bus.in_ready   = in_ready_w;
    assign bus.imem_wr_en = ~fifo_empty;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = fifo_empty ? 32'h0 : mem_q[rd_ptr_q];
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign err            = err_q;
    assign err_count      = err_count_q;

    // FIFO pointer/occupancy bookkeeping and storage of newly encoded words
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = enc.word;
            wr_ptr_d        = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Session FSM, write address counter and rejected-tuple reporting
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        err_d       = accept & ~enc.legal;
        err_count_d = err_count_q;
        if (accept && !enc.legal) begin
            err_count_d = sat_inc8(err_count_q);
        end
        if (pop) begin
            addr_d = addr_q + ADDR_W'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    addr_d  = base_addr;
                end
            end
            S_LOAD: begin
                if (accept && bus.in_last) begin
                    state_d = S_DRAIN;
                end
            end
            // Leave as soon as the last queued word is being written so done
            // follows the final write by exactly one cycle.
            S_DRAIN: begin
                if (count_d == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    // FIFO word storage; contents are qualified by the occupancy count
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed scenarios plus randomized
// sessions, all checked against a field-level arithmetic model of the encoder.
module tb_instr_encoder_loader;
    localparam int ADDR_W = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic        busy, done, err;
    logic [7:0]  err_count;

    instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder_loader #(.DEPTH(4), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .bus       (bus.slave),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [9:0]  cap_addr[$];
    logic [31:0] cap_data[$];
    int          cap_cyc[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          err_cnt = 0;

    logic [9:0]  exp_addr[$];
    logic [31:0] exp_data[$];
    logic [9:0]  next_addr = '0;
    int          model_errs = 0;
    int          sess_rejects = 0;
    bit          send_ok = 1'b1;
    bit          rand_ready = 1'b0;
    logic        ready_val = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // memory-side ready, changed shortly after each rising edge
    always @(posedge clk) begin
        #2;
        bus.imem_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
    end

    // observer: record completed writes and done/err pulses mid-cycle
    always @(negedge clk) begin
        if (bus.imem_wr_en === 1'b1 && bus.imem_ready === 1'b1) begin
            cap_addr.push_back(bus.imem_addr);
            cap_data.push_back(bus.imem_wdata);
            cap_cyc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (err === 1'b1) err_cnt = err_cnt + 1;
    end

    // Reference encoder built from the instruction field layout with plain arithmetic.
    function automatic bit model(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                                 input logic [4:0] rm, input logic [25:0] imm, output logic [31:0] w);
        int s;
        s = int'($signed(imm));
        w = 32'h0;
        case (op)
            4'd0: begin w = (32'h558 << 21) | (32'(rm) << 16) | (32'(rn) << 5) | 32'(rd); return 1'b1; end
            4'd1: begin w = (32'h758 << 21) | (32'(rm) << 16) | (32'(rn) << 5) | 32'(rd); return 1'b1; end
            4'd2: begin w = (32'h244 << 22) | ((32'(imm) & 32'hFFF) << 10) | (32'(rn) << 5) | 32'(rd); return imm < 26'd4096; end
            4'd3: begin w = (32'h344 << 22) | ((32'(imm) & 32'hFFF) << 10) | (32'(rn) << 5) | 32'(rd); return imm < 26'd4096; end
            4'd4: begin w = (32'h7C2 << 21) | ((32'(imm) & 32'h1FF) << 12) | (32'(rn) << 5) | 32'(rd); return (s >= -256 && s <= 255); end
            4'd5: begin w = (32'h7C0 << 21) | ((32'(imm) & 32'h1FF) << 12) | (32'(rn) << 5) | 32'(rd); return (s >= -256 && s <= 255); end
            4'd6: begin w = (32'd5 << 26) | 32'(imm); return 1'b1; end
            4'd7: begin w = (32'd37 << 26) | 32'(imm); return 1'b1; end
            4'd8: begin w = (32'hB4 << 24) | ((32'(imm) & 32'h7FFFF) << 5) | 32'(rd); return (s >= -262144 && s < 262144); end
            4'd9: begin w = 32'hD61F0000 | (32'(rn) << 5); return 1'b1; end
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        cap_addr.delete(); cap_data.delete(); cap_cyc.delete();
        exp_addr.delete(); exp_data.delete();
        done_cnt = 0; err_cnt = 0; sess_rejects = 0; send_ok = 1'b1;
    endtask

    task automatic begin_session(input logic [9:0] b);
        clear_obs();
        tick();
        start = 1'b1;
        base_addr = b;
        tick();
        start = 1'b0;
        next_addr = b;
    endtask

    // Present one tuple until accepted (bounded); update the model on acceptance.
    task automatic xfer(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                        input logic [4:0] rm, input logic [25:0] imm, input logic last);
        bit ok;
        bit legal;
        logic [31:0] w;
        bus.in_op = op; bus.in_rd = rd; bus.in_rn = rn; bus.in_rm = rm;
        bus.in_imm = imm; bus.in_last = last; bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        if (!ok) send_ok = 1'b0;
        else begin
            legal = model(op, rd, rn, rm, imm, w);
            if (legal) begin
                exp_addr.push_back(next_addr);
                exp_data.push_back(w);
                next_addr = next_addr + 10'd1;
            end else begin
                sess_rejects++;
                model_errs++;
            end
        end
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (done_cnt > 0) begin ok = 1'b1; break; end
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_status: busy=%b done=%b err=%b want 0", busy, done, err); end
        checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
        checks++; if (bus.in_ready !== 1'b0 || bus.imem_wr_en !== 1'b0) begin failures++; $display("FAIL reset_handshake: in_ready=%b wr_en=%b want 0", bus.in_ready, bus.imem_wr_en); end
        checks++; if (bus.imem_addr !== 10'h0 || bus.imem_wdata !== 32'h0) begin failures++; $display("FAIL reset_bus: addr=%h wdata=%h want 0", bus.imem_addr, bus.imem_wdata); end
        reset = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_release: busy=%b in_ready=%b want 0", busy, bus.in_ready); end
    endtask

    task automatic test_single_adds();
        bit ok;
        rand_ready = 1'b0; ready_val = 1'b1;
        begin_session(10'h010);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t1_busy: got %b want 1", busy); end
        xfer(4'd0, 5'd3, 5'd1, 5'd2, 26'd0, 1'b1);
        wait_done(50, ok);
        checks++; if (!(ok && send_ok)) begin failures++; $display("FAIL t1_timeout: done=%0d send_ok=%0d want 1", ok, send_ok); end
        checks++; if (cap_data.size() != 1) begin failures++; $display("FAIL t1_count: got %0d writes want 1", cap_data.size()); end
        else begin
            checks++; if (cap_data[0] !== 32'hAB020023 || cap_addr[0] !== 10'h010) begin failures++; $display("FAIL t1_word: got %h@%h want AB020023@010", cap_data[0], cap_addr[0]); end
            checks++; if (done_cyc != cap_cyc[0] + 1) begin failures++; $display("FAIL t1_done_timing: done cycle %0d write cycle %0d want +1", done_cyc, cap_cyc[0]); end
        end
        checks++; if (done_cnt != 1 || busy !== 1'b0) begin failures++; $display("FAIL t1_done_pulse: pulses=%0d busy=%b want 1/0", done_cnt, busy); end
    endtask

    task automatic test_addi_ldur();
        bit ok;
        begin_session(10'h100);
        xfer(4'd2, 5'd0, 5'd31, 5'd0, 26'd5, 1'b0);
        xfer(4'd4, 5'd4, 5'd5, 5'd0, 26'd8, 1'b1);
        wait_done(50, ok);
        checks++; if (!(ok && send_ok) || cap_data.size() != 2) begin failures++; $display("FAIL t2_count: writes=%0d done=%0d want 2/1", cap_data.size(), ok); end
        else begin
            checks++; if (cap_data[0] !== 32'h910017E0 || cap_addr[0] !== 10'h100) begin failures++; $display("FAIL t2_addi: got %h@%h want 910017E0@100", cap_data[0], cap_addr[0]); end
            checks++; if (cap_data[1] !== 32'hF84080A4 || cap_addr[1] !== 10'h101) begin failures++; $display("FAIL t2_ldur: got %h@%h want F84080A4@101", cap_data[1], cap_addr[1]); end
        end
    endtask

    task automatic test_cbz_br();
        bit ok;
        begin_session(10'h200);
        xfer(4'd8, 5'd9, 5'd0, 5'd0, 26'h3FFFFFE, 1'b0);
        xfer(4'd9, 5'd0, 5'd30, 5'd0, 26'($urandom), 1'b1);
        wait_done(50, ok);
        checks++; if (!(ok && send_ok) || cap_data.size() != 2) begin failures++; $display("FAIL t3_count: writes=%0d done=%0d want 2/1", cap_data.size(), ok); end
        else begin
            checks++; if (cap_data[0] !== 32'hB4FFFFC9) begin failures++; $display("FAIL t3_cbz: got %h want B4FFFFC9", cap_data[0]); end
            checks++; if (cap_data[1] !== 32'hD61F03C0) begin failures++; $display("FAIL t3_br: got %h want D61F03C0", cap_data[1]); end
        end
        checks++; if (err_cnt != 0) begin failures++; $display("FAIL t3_no_err: got %0d err pulses want 0", err_cnt); end
    endtask

    task automatic test_backpressure(input logic [9:0] b);
        bit ok;
        logic [4:0]  r5d, r5n;
        logic [25:0] i5;
        logic        s_en;
        logic [9:0]  s_addr;
        logic [31:0] s_data;
        bit stable;
        rand_ready = 1'b0; ready_val = 1'b0;
        begin_session(b);
        for (int k = 0; k < 4; k++)
            xfer(4'd2, 5'($urandom), 5'($urandom), 5'd0, 26'($urandom_range(0, 4095)), 1'b0);
        r5d = 5'($urandom); r5n = 5'($urandom); i5 = 26'($urandom_range(0, 4095));
        bus.in_op = 4'd2; bus.in_rd = r5d; bus.in_rn = r5n; bus.in_rm = 5'd0;
        bus.in_imm = i5; bus.in_last = 1'b0; bus.in_valid = 1'b1;
        @(negedge clk);
        s_en = bus.imem_wr_en; s_addr = bus.imem_addr; s_data = bus.imem_wdata;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL t4_full: in_ready=%b after 4 accepts want 0", bus.in_ready); end
        checks++; if (!send_ok || exp_data.size() != 4 || s_en !== 1'b1 || s_addr !== b || s_data !== exp_data[0]) begin failures++; $display("FAIL t4_head: en=%b %h@%h want 1 head@%h", s_en, s_data, s_addr, b); end
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.imem_wr_en !== s_en || bus.imem_addr !== s_addr || bus.imem_wdata !== s_data || bus.in_ready !== 1'b0) stable = 1'b0;
        end
        checks++; if (!stable) begin failures++; $display("FAIL t4_stable: bus moved while stalled, now en=%b %h@%h want %b %h@%h", bus.imem_wr_en, bus.imem_wdata, bus.imem_addr, s_en, s_data, s_addr); end
        ready_val = 1'b1;
        xfer(4'd2, r5d, r5n, 5'd0, i5, 1'b0);
        xfer(4'd2, 5'($urandom), 5'($urandom), 5'd0, 26'($urandom_range(0, 4095)), 1'b1);
        wait_done(100, ok);
        checks++; if (!(ok && send_ok) || cap_data.size() != 6) begin failures++; $display("FAIL t4_count: writes=%0d done=%0d want 6/1", cap_data.size(), ok); end
        else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (cap_data[k] !== exp_data[k] || cap_addr[k] !== exp_addr[k] || cap_addr[k] !== 10'(b + 10'(k)))
                    begin failures++; $display("FAIL t4_write%0d: got %h@%h want %h@%h", k, cap_data[k], cap_addr[k], exp_data[k], exp_addr[k]); end
            end
        end
    endtask

    task automatic test_errors();
        bit ok;
        int errs_before;
        errs_before = model_errs;
        begin_session(10'h300);
        xfer(4'hF, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL t5_err_pulse: err=%b after illegal op want 1", err); end
        xfer(4'd2, 5'd1, 5'd2, 5'd0, 26'd4096, 1'b0);
        xfer(4'd4, 5'd1, 5'd2, 5'd0, 26'd256, 1'b0);
        xfer(4'd6, 5'd0, 5'd0, 5'd0, 26'd1, 1'b1);
        wait_done(50, ok);
        checks++; if (err_cnt != 3 || sess_rejects != 3) begin failures++; $display("FAIL t5_err_pulses: got %0d pulses want 3", err_cnt); end
        checks++; if (err_count !== 8'(errs_before + 3)) begin failures++; $display("FAIL t5_err_count: got %0d want %0d", err_count, errs_before + 3); end
        checks++; if (!(ok && send_ok) || cap_data.size() != 1) begin failures++; $display("FAIL t5_count: writes=%0d done=%0d want 1/1", cap_data.size(), ok); end
        else begin
            checks++; if (cap_data[0] !== 32'h14000001 || cap_addr[0] !== 10'h300) begin failures++; $display("FAIL t5_b: got %h@%h want 14000001@300", cap_data[0], cap_addr[0]); end
        end
    endtask

    task automatic test_random();
        bit ok;
        int n, r;
        logic [3:0]  op;
        logic [25:0] imm;
        rand_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            begin_session(10'($urandom));
            n = $urandom_range(6, 14);
            for (int k = 0; k < n; k++) begin
                r = $urandom_range(0, 11);
                op = (r < 10) ? 4'(r) : 4'($urandom_range(10, 15));
                case ($urandom_range(0, 3))
                    0: imm = 26'($urandom_range(0, 300));
                    1: imm = 26'(-int'($urandom_range(1, 300)));
                    2: imm = 26'($urandom_range(0, 5000));
                    default: imm = 26'($urandom);
                endcase
                xfer(op, 5'($urandom), 5'($urandom), 5'($urandom), imm, k == n - 1);
            end
            wait_done(600, ok);
            checks++; if (!(ok && send_ok) || done_cnt != 1) begin failures++; $display("FAIL rand%0d_done: done=%0d pulses=%0d want 1", s, ok, done_cnt); end
            checks++; if (cap_data.size() != exp_data.size()) begin failures++; $display("FAIL rand%0d_count: got %0d writes want %0d", s, cap_data.size(), exp_data.size()); end
            else begin
                for (int k = 0; k < cap_data.size(); k++) begin
                    checks++;
                    if (cap_data[k] !== exp_data[k] || cap_addr[k] !== exp_addr[k])
                        begin failures++; $display("FAIL rand%0d_write%0d: got %h@%h want %h@%h", s, k, cap_data[k], cap_addr[k], exp_data[k], exp_addr[k]); end
                end
            end
            checks++; if (err_cnt != sess_rejects) begin failures++; $display("FAIL rand%0d_err: got %0d pulses want %0d", s, err_cnt, sess_rejects); end
            checks++; if (err_count !== 8'((model_errs > 255) ? 255 : model_errs)) begin failures++; $display("FAIL rand%0d_err_count: got %0d want %0d", s, err_count, model_errs); end
        end
        rand_ready = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        bit ok;
        bit idle_ok;
        ready_val = 1'b0;
        begin_session(10'h050);
        xfer(4'hC, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0);
        for (int k = 0; k < 3; k++)
            xfer(4'd2, 5'($urandom), 5'($urandom), 5'd0, 26'($urandom_range(0, 4095)), k == 2);
        tick();
        checks++; if (busy !== 1'b1 || bus.imem_wr_en !== 1'b1 || bus.in_ready !== 1'b0 || err_count === 8'd0) begin failures++; $display("FAIL t6_pre: busy=%b wr_en=%b in_ready=%b err_count=%0d want 1/1/0/nonzero", busy, bus.imem_wr_en, bus.in_ready, err_count); end
        #3;
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL t6_async_ctrl: busy=%b done=%b err=%b in_ready=%b want 0", busy, done, err, bus.in_ready); end
        checks++; if (bus.imem_wr_en !== 1'b0 || bus.imem_addr !== 10'h0 || bus.imem_wdata !== 32'h0 || err_count !== 8'd0) begin failures++; $display("FAIL t6_async_bus: wr_en=%b %h@%h err_count=%0d want 0", bus.imem_wr_en, bus.imem_wdata, bus.imem_addr, err_count); end
        ready_val = 1'b1;
        model_errs = 0;
        repeat (3) tick();
        reset = 1'b1;
        bus.in_op = 4'd6; bus.in_imm = 26'd7; bus.in_last = 1'b1; bus.in_valid = 1'b1;
        idle_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.imem_wr_en !== 1'b0) idle_ok = 1'b0;
        end
        bus.in_valid = 1'b0;
        checks++; if (!idle_ok || cap_data.size() != 0) begin failures++; $display("FAIL t6_post_idle: idle=%0d writes=%0d want 1/0", idle_ok, cap_data.size()); end
        checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL t6_err_count: got %0d want 0", err_count); end
        begin_session(10'h060);
        xfer(4'd6, 5'd0, 5'd0, 5'd0, 26'd1, 1'b1);
        wait_done(50, ok);
        checks++; if (!(ok && send_ok) || cap_data.size() != 1) begin failures++; $display("FAIL t6_resume_count: writes=%0d done=%0d want 1/1", cap_data.size(), ok); end
        else begin
            checks++; if (cap_data[0] !== 32'h14000001 || cap_addr[0] !== 10'h060) begin failures++; $display("FAIL t6_resume: got %h@%h want 14000001@060", cap_data[0], cap_addr[0]); end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rd = '0; bus.in_rn = '0;
        bus.in_rm = '0; bus.in_imm = '0; bus.in_last = 1'b0; bus.imem_ready = 1'b0;
        test_reset();
        test_single_adds();
        test_addi_ldur();
        test_cbz_br();
        test_backpressure(10'h020);
        test_backpressure(10'h3FF);
        test_errors();
        test_random();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
